// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// idle line level and the parity-bit calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Data narrower than 8 bits is zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. Parity is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam int             BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx: illegal parameter value");
    end

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shift;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    assign tx_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= LINE_IDLE;
            tx_busy  <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd <= LINE_IDLE;
                    if (tx_valid) begin
                        shift   <= tx_data;
                        tx_busy <= 1'b1;
                        state   <= ARM;
`ifdef UART_TX_PARITY_EN
                        parity_q <= calc_parity(8'(tx_data), PARITY_ODD != 0);
`endif
                    end
                end
                // A tick on the accept edge is seen in IDLE, so ARM only counts later ticks.
                ARM: begin
                    if (baud_tick) begin
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        txd     <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            txd   <= parity_q;
                            state <= PARITY;
`else
                            txd   <= LINE_IDLE;
                            state <= STOP;
`endif
                        end else begin
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        txd   <= LINE_IDLE;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    txd     <= LINE_IDLE;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
